fp8_mac_pipelined: RTL and testbench
====================================

Name: fp8_mac_pipelined

Overview:
Fully pipelined FP8 (E4M3) multiply-add datapath: result = round(round(a*b) + c), not fused. A 3-stage multiplier sub-block feeds a 3-stage adder sub-block, so total latency is 6 cycles. It accepts one operation per cycle. It is the arithmetic core of the FP8 MAC unit: the caller feeds the running accumulator back on c96 to form dot products.

Parameters:
MUL_STAGES, 3, register stages in the multiplier path (fixed; documented for the bench).
ADD_STAGES, 3, register stages in the adder path (fixed).

Ports:
clk96  in  1  single clock, rising edge.
rst96  in  1  asynchronous, active-high reset.
in_valid96  in  1  operands on a96/b96/c96 are valid this cycle.
a96  in  8  FP8 multiplicand.
b96  in  8  FP8 multiplier.
c96  in  8  FP8 addend (accumulator), sampled in the same cycle as a96/b96.
mult_result96  out  8  registered product a*b, 3 cycles after sampling.
result96  out  8  registered a*b+c, 6 cycles after sampling.
out_valid96  out  1  result96 is valid (in_valid96 delayed by 6 cycles).

Behaviour:
- Reset: while rst96=1 all pipeline registers clear asynchronously; mult_result96=0x00, result96=0x00, out_valid96=0. Reset asserted mid-operation discards all in-flight operations.
- Format E4M3: bit7 sign, bits6:3 exponent with bias 7, bits2:0 mantissa with hidden 1. Example: 0x38 = 1.0, 0x48 = 4.0.
- No Inf/NaN: every encoding with exponent 1..15 is finite. Maximum magnitude is 0x7F/0xFF = ±480.
- Exponent field 0 (zero or subnormal) is treated as zero on input. Results below 2^-6 flush to +0 (0x00). An exact-zero sum is +0.
- Overflow saturates to ±max (0x7F/0xFF), never wraps.
- Rounding: round-to-nearest-even on the 3-bit mantissa, using guard/round/sticky bits. Mantissa carry-out on rounding increments the exponent, and that exponent is then rechecked for saturation.
- Multiplier: sign = sa^sb. Exponent = ea+eb-7. 4x4 significand product, normalised by at most 1 bit, then rounded.
  - Stage 1: register unpacked fields.
  - Stage 2: register raw product and exponent.
  - Stage 3: normalise, round, pack into the mult_result96 register.
- Adder: operands are mult_result96 and c96 delayed by 3 cycles, so both belong to the same operation.
  - Stage 1: compare magnitudes, swap, register exponent difference.
  - Stage 2: align the smaller operand (shift ≤ 8 plus sticky bit), add or subtract, register.
  - Stage 3: leading-zero normalise, round, saturate or flush, pack into result96.
  - Effective subtraction of equal magnitudes gives 0x00.
- Throughput: new operands every cycle. No stalls and no backpressure.
- Data outputs update every cycle regardless of valid; only out_valid96 qualifies result96.

Decomposition:
- Shared package fp8_pkg holds:
  - constants EXP_BIAS=7, EXP_W=4, MAN_W=3, FP8_MAX_POS=8'h7F, FP8_ZERO=8'h00;
  - an unpacked struct {sign, exp, sig};
  - functions for unpack and for round-and-pack with saturate.
- One natural sub-module: fp8_mul_stage3, the 3-stage multiplier. The adder stages and the c96 delay line live in the top level.

Test Plan:
- Reset: hold rst96=1 with random inputs -> mult_result96=0x00, result96=0x00, out_valid96=0. Assert rst96 mid-stream -> outputs clear immediately, asynchronously to clk96.
- Latency and exact products: a=0x48 b=0x44 c=0x00 at cycle N -> mult_result96=0x54 (12.0) after edge N+3, result96=0x54 after N+6. Further products: 0x40*0xC6 -> 0xCE (-7.0); 0x44*0x44 -> 0x51 (9.0); 0x33*0x38 -> 0x33.
- Rounding and add: 0x33*0x33 -> 0x2F (RNE). a=0x48 b=0x38 c=0x33 -> result96=0x49 (4.6875 rounds to 4.5). 0x38*0x38 + 0x38 -> 0x40.
- Cancellation and mixed sign: a=0x48 b=0x38 c=0xC6 -> 0x30 (0.5). a=0x40 b=0x38 c=0xC0 -> 0x00.
- Saturation and flush: 0x7F*0x40 -> 0x7F; 0xFF*0x40 -> 0xFF; 0x08*0x08 -> 0x00; any operand with exponent 0 -> product 0x00.
- Back-to-back stream: 12 consecutive operand pairs, one per cycle, with in_valid96 high -> 12 consecutive out_valid96 pulses. Each result96 matches a Python E4M3 model with no bubbles or reordering.

Source files
------------

// File: rtl/fp8_pkg.sv
// E4M3 FP8 shared types, constants and pack/unpack helpers.
// Used by the multiplier sub-block and the MAC top level.
package fp8_pkg;

    localparam int EXP_BIAS   = 7;
    localparam int EXP_W      = 4;
    localparam int MAN_W      = 3;
    localparam int MUL_STAGES = 3;
    localparam int ADD_STAGES = 3;

    localparam logic [7:0] FP8_MAX_POS = 8'h7F;
    localparam logic [7:0] FP8_ZERO    = 8'h00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
    } fp8_unp_t;

    typedef struct packed {
        logic       sign;
        logic [6:0] exp;
        logic [7:0] prod;
    } mul_s2_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] shift;
        logic       sub;
    } add_s1_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [7:0] sum;
    } add_s2_t;

    function automatic fp8_unp_t fp8_unpack(input logic [7:0] x);
        fp8_unp_t u;
        u.sign = x[7];
        u.exp  = x[6:3];
        u.sig  = (x[6:3] == 4'd0) ? 4'd0 : {1'b1, x[2:0]};
        return u;
    endfunction

    // frac holds the bits below the leading one: mantissa, guard, sticky.
    function automatic logic [7:0] fp8_round_pack(
        input logic       sign,
        input logic [6:0] exp,
        input logic [6:0] frac
    );
        logic       rnd;
        logic [3:0] man;
        logic [6:0] e;
        logic [7:0] r;
        rnd = frac[3] & (frac[4] | (|frac[2:0]));
        man = {1'b0, frac[6:4]} + {3'b000, rnd};
        e   = exp + {6'd0, man[3]};
        if (exp[6] || exp == 7'd0) begin
            r = FP8_ZERO;
        end else if (e > 7'd15) begin
            r = {sign, FP8_MAX_POS[6:0]};
        end else begin
            r = {sign, e[3:0], man[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fp8_mul_stage3.sv
// Three-stage E4M3 multiplier: unpack, 4x4 product, normalise/round/pack.
// Zero or subnormal inputs give +0; overflow saturates.
module fp8_mul_stage3
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    fp8_unp_t   ua_d, ua_q;
    fp8_unp_t   ub_d, ub_q;
    mul_s2_t    s2_d, s2_q;
    logic [7:0] p_d, p_q;
    logic [6:0] frac;

    always_comb begin
        ua_d = fp8_unpack(a);
        ub_d = fp8_unpack(b);

        s2_d.sign = ua_q.sign ^ ub_q.sign;
        s2_d.exp  = 7'(ua_q.exp) + 7'(ub_q.exp) - 7'(EXP_BIAS);
        s2_d.prod = 8'(ua_q.sig) * 8'(ub_q.sig);

        // product of two 1.xxx values lies in [1,4): shift by at most one
        frac = s2_q.prod[7] ? s2_q.prod[6:0]
                            : {s2_q.prod[5:0], 1'b0};
        p_d  = FP8_ZERO;
        if (s2_q.prod != 8'd0) begin
            p_d = fp8_round_pack(s2_q.sign,
                                 s2_q.exp + 7'(s2_q.prod[7]),
                                 frac);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ua_q <= '0;
            ub_q <= '0;
            s2_q <= '0;
            p_q  <= '0;
        end else begin
            ua_q <= ua_d;
            ub_q <= ub_d;
            s2_q <= s2_d;
            p_q  <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/fp8_mac_pipelined.sv
// Pipelined E4M3 multiply-then-add: round(round(a*b) + c), 6-cycle latency.
// Multiplier sub-block feeds a 3-stage adder; c is delayed to stay aligned.
module fp8_mac_pipelined
    import fp8_pkg::*;
(
    input  logic       clk96,
    input  logic       rst96,
    input  logic       in_valid96,
    input  logic [7:0] a96,
    input  logic [7:0] b96,
    input  logic [7:0] c96,
    output logic [7:0] mult_result96,
    output logic [7:0] result96,
    output logic       out_valid96
);

    localparam int LAT = MUL_STAGES + ADD_STAGES;

    logic [MUL_STAGES-1:0][7:0] c_dly_d, c_dly_q;
    logic [LAT-1:0]             vld_d, vld_q;

    add_s1_t    s1_d, s1_q;
    add_s2_t    s2_d, s2_q;
    logic [7:0] res_d, res_q;

    fp8_unp_t   ux, uy, op_hi, op_lo;
    logic [3:0] diff;
    logic [14:0] sh;
    logic       sticky;
    logic [6:0] al;
    logic [7:0] hi_ext;
    logic [2:0] lead;
    logic [6:0] frac;
    logic [6:0] e_norm;

    fp8_mul_stage3 u_mul (
        .clk (clk96),
        .rst (rst96),
        .a   (a96),
        .b   (b96),
        .p   (mult_result96)
    );

    always_comb begin
        c_dly_d = {c_dly_q[MUL_STAGES-2:0], c96};
        vld_d   = {vld_q[LAT-2:0], in_valid96};
    end

    // stage 1: order operands by magnitude
    always_comb begin
        ux = fp8_unpack(mult_result96);
        uy = fp8_unpack(c_dly_q[MUL_STAGES-1]);
        if ({ux.exp, ux.sig} >= {uy.exp, uy.sig}) begin
            op_hi = ux;
            op_lo = uy;
        end else begin
            op_hi = uy;
            op_lo = ux;
        end
        diff       = op_hi.exp - op_lo.exp;
        s1_d.sign  = op_hi.sign;
        s1_d.exp   = op_hi.exp;
        s1_d.hi    = op_hi.sig;
        s1_d.lo    = op_lo.sig;
        s1_d.shift = (diff > 4'd8) ? 4'd8 : diff;
        s1_d.sub   = op_hi.sign ^ op_lo.sign;
    end

    // stage 2: align with guard/round/sticky, then add or subtract
    always_comb begin
        sh     = {s1_q.lo, 3'b000, 8'h00} >> s1_q.shift;
        sticky = |sh[7:0];
        al     = sh[14:8] | {6'd0, sticky};
        hi_ext = {1'b0, s1_q.hi, 3'b000};
        s2_d.sign = s1_q.sign;
        s2_d.exp  = s1_q.exp;
        s2_d.sum  = s1_q.sub ? hi_ext - {1'b0, al}
                             : hi_ext + {1'b0, al};
    end

    // stage 3: leading-one normalise, round, flush or saturate
    always_comb begin
        lead = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s2_q.sum[i]) lead = 3'(i);
        end
        frac   = 7'(s2_q.sum << (3'd7 - lead));
        e_norm = 7'(s2_q.exp) + 7'(lead) - 7'd6;
        res_d  = FP8_ZERO;
        if (s2_q.sum != 8'd0) begin
            res_d = fp8_round_pack(s2_q.sign, e_norm, frac);
        end
    end

    always_ff @(posedge clk96 or posedge rst96) begin
        if (rst96) begin
            c_dly_q <= '0;
            vld_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            res_q   <= '0;
        end else begin
            c_dly_q <= c_dly_d;
            vld_q   <= vld_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res_q   <= res_d;
        end
    end

    assign result96    = res_q;
    assign out_valid96 = vld_q[LAT-1];

endmodule

// File: tb/tb_fp8_mac_pipelined.sv
// Scoreboard bench for fp8_mac_pipelined against a real-valued E4M3 model.
// Directed vectors carry fixed expectations; random ones use the model.
module tb_fp8_mac_pipelined;

    logic       clk96 = 1'b0;
    logic       rst96 = 1'b1;
    logic       in_valid96 = 1'b0;
    logic [7:0] a96 = 8'h00;
    logic [7:0] b96 = 8'h00;
    logic [7:0] c96 = 8'h00;
    logic [7:0] mult_result96;
    logic [7:0] result96;
    logic       out_valid96;

    fp8_mac_pipelined dut (
        .clk96         (clk96),
        .rst96         (rst96),
        .in_valid96    (in_valid96),
        .a96           (a96),
        .b96           (b96),
        .c96           (c96),
        .mult_result96 (mult_result96),
        .result96      (result96),
        .out_valid96   (out_valid96)
    );

    always #5 clk96 = ~clk96;

    int cyc = 0;
    always @(posedge clk96) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         iss;
        logic [7:0] mul;
        logic [7:0] res;
    } exp_t;

    exp_t sb[$];
    exp_t mq[$];

    logic [39:0] dir_tab [18];

    function automatic real p2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real dec(input logic [7:0] x);
        real v;
        if (x[6:3] == 4'd0) return 0.0;
        v = (8.0 + x[2:0]) / 8.0 * p2(int'(x[6:3]) - 7);
        return x[7] ? -v : v;
    endfunction

    function automatic logic [7:0] enc(input real v);
        logic s;
        real  a;
        real  m;
        real  fr;
        int   e;
        int   fl;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a < p2(-6)) return 8'h00;
        e = -6;
        while (e < 9 && a >= p2(e + 1)) e++;
        if (e > 8) return {s, 7'h7F};
        m  = a / p2(e) * 8.0;
        fl = $rtoi(m);
        fr = m - fl;
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 16) begin
            fl = 8;
            e++;
        end
        if (e > 8) return {s, 7'h7F};
        return {s, 4'(e + 7), 3'(fl - 8)};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] m,
                        input logic [7:0] r);
        exp_t t;
        @(negedge clk96);
        a96 = a;
        b96 = b;
        c96 = c;
        in_valid96 = 1'b1;
        t.iss = cyc;
        t.mul = m;
        t.res = r;
        sb.push_back(t);
        mq.push_back(t);
    endtask

    task automatic issue_model(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c);
        logic [7:0] pm;
        logic [7:0] pr;
        pm = enc(dec(a) * dec(b));
        pr = enc(dec(pm) + dec(c));
        push(a, b, c, pm, pr);
    endtask

    task automatic idle();
        @(negedge clk96);
        in_valid96 = 1'b0;
        a96 = 8'($urandom);
        b96 = 8'($urandom);
        c96 = 8'($urandom);
    endtask

    // monitor: product 3 cycles after issue, sum with out_valid96
    initial begin
        exp_t t;
        forever begin
            @(negedge clk96);
            if (mq.size() > 0 && mq[0].iss + 3 == cyc) begin
                t = mq.pop_front();
                chk("mult_result", mult_result96, t.mul);
            end
            if (out_valid96) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got out_valid96=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    t = sb.pop_front();
                    chk("result", result96, t.res);
                    chk("latency", cyc - t.iss, 6);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        dir_tab = '{
            40'h48_44_00_54_54, 40'h40_C6_00_CE_CE, 40'h44_44_00_51_51,
            40'h33_38_00_33_33, 40'h33_33_00_2F_2F, 40'h48_38_33_48_49,
            40'h38_38_38_38_40, 40'h48_38_C6_48_30, 40'h40_38_C0_40_00,
            40'h7F_40_00_7F_7F, 40'hFF_40_00_FF_FF, 40'h08_08_00_00_00,
            40'h05_48_38_00_38, 40'h7F_38_7F_7F_7F, 40'h38_38_B8_38_00,
            40'h08_38_89_08_00, 40'h38_38_18_38_38, 40'h39_38_18_39_3A
        };

        rst96 = 1'b1;
        repeat (3) begin
            @(negedge clk96);
            in_valid96 = 1'($urandom);
            a96 = 8'($urandom);
            b96 = 8'($urandom);
            c96 = 8'($urandom);
            #1;
            chk("rst_mult", mult_result96, 8'h00);
            chk("rst_result", result96, 8'h00);
            chk("rst_valid", out_valid96, 0);
        end
        @(negedge clk96);
        in_valid96 = 1'b0;
        rst96 = 1'b0;

        foreach (dir_tab[i]) begin
            push(dir_tab[i][39:32], dir_tab[i][31:24], dir_tab[i][23:16],
                 dir_tab[i][15:8], dir_tab[i][7:0]);
        end

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue_model(8'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (12) issue_model(8'($urandom), 8'($urandom), 8'($urandom));

        @(posedge clk96);
        #2;
        rst96 = 1'b1;
        in_valid96 = 1'b0;
        #1;
        chk("async_rst_mult", mult_result96, 8'h00);
        chk("async_rst_result", result96, 8'h00);
        chk("async_rst_valid", out_valid96, 0);
        sb.delete();
        mq.delete();
        @(negedge clk96);
        @(negedge clk96);
        rst96 = 1'b0;
        repeat (8) idle();
        chk("post_rst_valid", out_valid96, 0);

        repeat (60) begin
            if ($urandom_range(0, 4) == 0) idle();
            else issue_model(8'($urandom), 8'($urandom), 8'($urandom));
        end

        idle();
        t = 0;
        while ((sb.size() > 0 || mq.size() > 0) && t < 20) begin
            @(negedge clk96);
            t++;
        end
        chk("drain_pending", sb.size() + mq.size(), 0);
        repeat (2) @(negedge clk96);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
